// File: rtl/op_sequencer.sv
// op_sequencer: issues a counted run of start pulses to a downstream
// unit, pacing each on its done pulse, with abort and error tracking.
module op_sequencer #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [CNT_WIDTH-1:0] cmd_count,
  input  logic                 abort,
  output logic                 op_start,
  output logic [CNT_WIDTH-1:0] op_index,
  input  logic                 op_done,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic                 error
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    FINISH
  } state_t;

  state_t state;
  state_t state_nx;

  logic [CNT_WIDTH-1:0] idx;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 err_q;
  logic                 abort_q;
  logic                 accept;
  logic                 last;
  logic                 abort_hit;
  logic                 step_idx;

  assign accept    = (state == IDLE) && cmd_valid;
  assign last      = (idx == cnt - CNT_WIDTH'(1));
  assign abort_hit = abort && (state != IDLE);
  assign step_idx  = (state == WAIT) && op_done
                     && !abort && !last;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next-state logic; abort overrides every other transition
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (cmd_valid)
          state_nx = (cmd_count == '0) ? FINISH : ISSUE;
      end
      ISSUE: state_nx = WAIT;
      WAIT: begin
        if (op_done)
          state_nx = last ? FINISH : ISSUE;
      end
      FINISH: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (abort_hit) state_nx = IDLE;
  end

  // outputs decoded from registered state
  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b0;
    op_start  = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE:   cmd_ready = 1'b1;
      ISSUE: begin
        busy     = 1'b1;
        op_start = 1'b1;
      end
      WAIT:   busy = 1'b1;
      FINISH: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: cmd_ready = 1'b0;
    endcase
  end

  assign op_index = idx;
  assign error    = err_q;
  assign aborted  = abort_q;

  // latched count and running index; index holds after completion
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
      cnt <= '0;
    end else if (accept) begin
      idx <= '0;
      cnt <= cmd_count;
    end else if (step_idx) begin
      idx <= idx + CNT_WIDTH'(1);
    end
  end

  // abort pulse and sticky error; a new error beats the clear
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      abort_q <= abort_hit;
      if (op_done && (state != WAIT)) err_q <= 1'b1;
      else if (accept)                err_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_op_sequencer.sv
// tb_op_sequencer: scenario tasks plus randomized command runs,
// each checked against the expected operation trace of a command.
module tb_op_sequencer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic [W-1:0] cmd_count;
  logic         abort;
  logic         op_done;
  logic         cmd_ready;
  logic         op_start;
  logic [W-1:0] op_index;
  logic         busy;
  logic         done;
  logic         aborted;
  logic         error;

  logic [2:0]   cmd_count_w;
  logic         cmd_ready_w;
  logic         op_start_w;
  logic [2:0]   op_index_w;
  logic         busy_w;
  logic         done_w;
  logic         aborted_w;
  logic         error_w;

  int errs   = 0;
  int checks = 0;

  assign cmd_count_w = cmd_count[2:0];

  op_sequencer #(.CNT_WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_count(cmd_count), .abort(abort),
    .op_start(op_start), .op_index(op_index),
    .op_done(op_done), .busy(busy), .done(done),
    .aborted(aborted), .error(error)
  );

  op_sequencer #(.CNT_WIDTH(3)) dut_w (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_w),
    .cmd_count(cmd_count_w), .abort(abort),
    .op_start(op_start_w), .op_index(op_index_w),
    .op_done(op_done), .busy(busy_w), .done(done_w),
    .aborted(aborted_w), .error(error_w)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // obs = {cmd_ready,busy,op_start,done,aborted,error,op_index}
  function automatic logic [W+5:0] obs();
    return {cmd_ready, busy, op_start, done, aborted, error, op_index};
  endfunction

  function automatic logic [W+5:0] mk(
    input bit rdy, input bit bsy, input bit st, input bit dn,
    input bit ab, input bit er, input int ix);
    return {rdy, bsy, st, dn, ab, er, W'(ix)};
  endfunction

  // One command as seen from outside: accept, then for op i a start
  // with index i, a done pulse d cycles later, and either the next
  // start, done, or (at ab_op) an abort one cycle after that.
  task automatic run_cmd(input int n, input int dly, input int ab_op,
                         input bit ab_done, input bit spur,
                         input bit chkw);
    int d;
    logic [W+5:0] e;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errs++;
      $display("FAIL accept_ready got=%0b exp=1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_count = W'(n);
    op_done   = spur;
    step();
    cmd_valid = 1'b0;
    op_done   = 1'b0;
    abort     = 1'b0;
    cmd_count = W'($urandom);
    if (n == 0) begin
      e = mk(0, 1, 0, 1, 0, spur, 0);
      checks++;
      if (obs() !== e) begin
        errs++;
        $display("FAIL zero_finish got=%h exp=%h", obs(), e);
      end
      step();
      e = mk(1, 0, 0, 0, 0, spur, 0);
      checks++;
      if (obs() !== e) begin
        errs++;
        $display("FAIL zero_idle got=%h exp=%h", obs(), e);
      end
      return;
    end
    for (int i = 0; i < n; i++) begin
      e = mk(0, 1, 1, 0, 0, spur, i);
      checks++;
      if (obs() !== e) begin
        errs++;
        $display("FAIL issue%0d got=%h exp=%h", i, obs(), e);
      end
      if (chkw) begin
        checks++;
        if ({op_start_w, op_index_w} !== {1'b1, 3'(i)}) begin
          errs++;
          $display("FAIL wide_issue%0d got=%b/%0d exp=1/%0d",
                   i, op_start_w, op_index_w, i);
        end
      end
      d = (dly > 0) ? dly : int'($urandom_range(1, 4));
      step();
      for (int k = 1; k < d; k++) begin
        e = mk(0, 1, 0, 0, 0, spur, i);
        checks++;
        if (obs() !== e) begin
          errs++;
          $display("FAIL wait%0d got=%h exp=%h", i, obs(), e);
        end
        step();
      end
      op_done = 1'b1;
      if (i == ab_op) begin
        abort   = 1'b1;
        op_done = ab_done;
      end
      step();
      op_done = 1'b0;
      abort   = 1'b0;
      if (i == ab_op) begin
        e = mk(1, 0, 0, 0, 1, spur, i);
        checks++;
        if (obs() !== e) begin
          errs++;
          $display("FAIL abort%0d got=%h exp=%h", i, obs(), e);
        end
        step();
        e = mk(1, 0, 0, 0, 0, spur, i);
        checks++;
        if (obs() !== e) begin
          errs++;
          $display("FAIL post_abort got=%h exp=%h", obs(), e);
        end
        return;
      end
    end
    e = mk(0, 1, 0, 1, 0, spur, n - 1);
    checks++;
    if (obs() !== e) begin
      errs++;
      $display("FAIL done got=%h exp=%h", obs(), e);
    end
    if (chkw) begin
      checks++;
      if (done_w !== 1'b1) begin
        errs++;
        $display("FAIL wide_done got=%b exp=1", done_w);
      end
    end
    step();
    e = mk(1, 0, 0, 0, 0, spur, n - 1);
    checks++;
    if (obs() !== e) begin
      errs++;
      $display("FAIL end_idle got=%h exp=%h", obs(), e);
    end
  endtask

  task automatic test_reset();
    logic [W+5:0] e;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_count = '0;
    abort     = 1'b0;
    op_done   = 1'b0;
    step();
    step();
    rst = 1'b0;
    e = mk(1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs() !== e) begin
      errs++;
      $display("FAIL reset got=%h exp=%h", obs(), e);
    end
  endtask

  task automatic test_normal();
    run_cmd(3, 4, -1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_zero();
    run_cmd(0, 1, -1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_abort();
    run_cmd(5, 3, 2, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_abort_last();
    run_cmd(3, 2, 2, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_spurious();
    run_cmd(2, 0, -1, 1'b0, 1'b1, 1'b0);
    run_cmd(0, 1, -1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    logic [W+5:0] e;
    cmd_valid = 1'b1;
    cmd_count = W'(4);
    step();
    cmd_valid = 1'b0;
    step();
    op_done = 1'b1;
    step();
    op_done = 1'b0;
    step();
    e = mk(0, 1, 0, 0, 0, 0, 1);
    checks++;
    if (obs() !== e) begin
      errs++;
      $display("FAIL mid_wait got=%h exp=%h", obs(), e);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    e = mk(1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs() !== e) begin
      errs++;
      $display("FAIL mid_reset got=%h exp=%h", obs(), e);
    end
    run_cmd(1, 2, -1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_wide();
    run_cmd(7, 1, -1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    int n;
    int ab;
    int gap;
    for (int c = 0; c < 30; c++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        abort = 1'($urandom_range(0, 1));
        step();
        checks++;
        if ({cmd_ready, aborted, busy} !== 3'b100) begin
          errs++;
          $display("FAIL idle_abort got=%b exp=100",
                   {cmd_ready, aborted, busy});
        end
      end
      n  = $urandom_range(0, 6);
      ab = -1;
      if (n > 0 && $urandom_range(0, 3) == 0)
        ab = $urandom_range(0, n - 1);
      run_cmd(n, 0, ab, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_zero();
    test_abort();
    test_abort_last();
    test_spurious();
    test_reset_mid();
    test_wide();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/op_sequencer.md
OP_SEQUENCER -- requirements
Module: op_sequencer

Interface
REQ-001 The block SHALL have one parameter: CNT_WIDTH, default 16, width of the operation count and index.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 The block SHALL have port cmd_valid, input, 1, command request.
REQ-005 The block SHALL have port cmd_ready, output, 1, command accepted when cmd_valid and cmd_ready are both high.
REQ-006 The block SHALL have port cmd_count, input, CNT_WIDTH, number of operations to run; unsigned.
REQ-007 The block SHALL have port abort, input, 1, cancels a running command.
REQ-008 The block SHALL have port op_start, output, 1, one-cycle start pulse to the downstream compute unit.
REQ-009 The block SHALL have port op_index, output, CNT_WIDTH, zero-based index of the current operation.
REQ-010 The block SHALL have port op_done, input, 1, one-cycle completion pulse from the downstream unit.
REQ-011 The block SHALL have port busy, output, 1, high while a command is in progress.
REQ-012 The block SHALL have port done, output, 1, one-cycle pulse on normal command completion.
REQ-013 The block SHALL have port aborted, output, 1, one-cycle pulse when abort terminates a command.
REQ-014 The block SHALL have port error, output, 1, sticky flag for an unexpected op_done.

Function
REQ-015 The block SHALL implement states IDLE, ISSUE, WAIT and FINISH; all outputs are registered or decoded from registered state.
REQ-016 cmd_ready SHALL be high exactly when the state is IDLE; busy SHALL be high exactly when the state is not IDLE.
REQ-017 On acceptance in IDLE with cmd_count nonzero, the block SHALL latch cmd_count, clear the index to 0 and go to ISSUE.
REQ-018 On acceptance in IDLE with cmd_count equal to 0, the block SHALL go directly to FINISH, issuing no op_start.
REQ-019 In ISSUE, op_start SHALL be high for exactly one cycle and op_index SHALL equal the current index; the next state is WAIT.
REQ-020 In WAIT with op_done high and index equal to latched count minus 1, the next state SHALL be FINISH.
REQ-021 In WAIT with op_done high and index below latched count minus 1, the block SHALL increment the index and go to ISSUE.
REQ-022 In WAIT with op_done low, the block SHALL hold state and index indefinitely; there is no timeout.
REQ-023 In FINISH, done SHALL be high for one cycle; the next state is IDLE.
REQ-024 Latency: accept at cycle T SHALL give op_start at T+1; op_done at cycle D SHALL give the next op_start, or done, at D+1.
REQ-025 op_index SHALL hold its value between op_start pulses and after completion, until the next command is accepted.
REQ-026 Index arithmetic SHALL be CNT_WIDTH-bit unsigned; a count of 2^CNT_WIDTH-1 SHALL run every index 0 through 2^CNT_WIDTH-2 without wrap.
REQ-027 abort high in ISSUE, WAIT or FINISH SHALL force IDLE on the next edge, pulse aborted for one cycle, and suppress done and any further op_start.
REQ-028 abort SHALL take priority over op_done in the same cycle; abort in IDLE SHALL have no effect and SHALL NOT block acceptance.
REQ-029 op_done high in IDLE, ISSUE or FINISH SHALL be ignored for sequencing and SHALL set error.
REQ-030 error SHALL be cleared on command acceptance; if a clear and a set occur in the same cycle, the set SHALL win.
REQ-031 cmd_count and cmd_valid SHALL be ignored outside IDLE.

Reset
REQ-032 While rst is high, the block SHALL force IDLE, index 0, latched count 0, and error 0.
REQ-033 Immediately after reset, outputs SHALL be: cmd_ready 1; op_start, busy, done, aborted and error 0; op_index 0.
REQ-034 Reset mid-command SHALL discard the command without pulsing done or aborted.

Verification
REQ-035 Normal run: count=3, op_done 4 cycles after each op_start -> op_start with op_index 0, 1, 2; a single done pulse 1 cycle after the third op_done; busy high from accept+1 to done.
REQ-036 Zero count: count=0 accepted at T -> busy at T+1, done at T+1, cmd_ready at T+2, no op_start.
REQ-037 Abort: count=5, abort asserted in WAIT after op_index=2 -> aborted pulse next cycle, IDLE, no done, op_index stays 2.
REQ-038 Simultaneous abort and op_done on the last operation -> aborted pulses, done does not.
REQ-039 Spurious op_done in IDLE in the same cycle as command acceptance -> error=1 after the edge; the command still runs; the next acceptance without op_done clears error.
REQ-040 rst asserted in WAIT with count=4 at index 1 -> next cycle matches REQ-033; a new count=1 command completes normally.
